// File: rtl/opll_bus_pkg.sv
// opll_bus_pkg: shared FSM states, YM2413 write-timing constants and the
// buffered (addr, data) pair type for the OPLL CPU-bus write sequencer.
package opll_bus_pkg;

    localparam int OPLL_ADDR_WAIT_CLK = 12;
    localparam int OPLL_DATA_WAIT_CLK = 84;
    localparam int OPLL_WR_PULSE_CLK  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_STB,
        ST_ADDR_WAIT,
        ST_DATA_STB,
        ST_DATA_WAIT
    } opll_state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } opll_pair_t;

    function automatic int max3(input int a, input int b, input int c);
        max3 = (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/opll_wr_fifo.sv
// opll_wr_fifo: 16-bit synchronous FIFO holding {addr, data} write pairs.
// Ports: clk, reset (sync, active high), push_i/wdata_i write side,
// pop_i/rdata_o read side (rdata_o shows the head entry), count_o occupancy,
// empty_o. Pushes while full and pops while empty are ignored.
module opll_wr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [15:0]              wdata_i,
    input  logic                     pop_i,
    output logic [15:0]              rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push_i && (count_q < CW'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: only entries below count_q are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/opll_write_sequencer.sv
// opll_write_sequencer: buffers (addr, data) register writes and replays them
// onto the YM2413 CPU bus with the chip's strobe width and post-write waits.
// Ports: clk (also OPLL XIN), reset (sync, active high);
// requester side i_valid/i_addr/i_data with o_ready handshake;
// status o_busy and o_fifo_count;
// OPLL bus pins o_CS_n, o_WR_n, o_A0 (0 = address, 1 = data), o_D, all registered.
module opll_write_sequencer
    import opll_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_PULSE   = OPLL_WR_PULSE_CLK,
    parameter int ADDR_WAIT  = OPLL_ADDR_WAIT_CLK,
    parameter int DATA_WAIT  = OPLL_DATA_WAIT_CLK
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_valid,
    input  logic [7:0]                    i_addr,
    input  logic [7:0]                    i_data,
    output logic                          o_ready,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_CS_n,
    output logic                          o_WR_n,
    output logic                          o_A0,
    output logic [7:0]                    o_D
);

    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(max3(WR_PULSE, ADDR_WAIT, DATA_WAIT) + 1);

    opll_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stb_n_q, stb_n_d;
    logic          a0_q, a0_d;
    logic [7:0]    bus_q, bus_d;
    logic [7:0]    data_q, data_d;
    logic          push;
    logic          start;
    logic          empty;
    logic [15:0]   head;
    opll_pair_t    head_pair;
    logic [FW-1:0] count;

    assign o_ready      = !reset && (count < FW'(FIFO_DEPTH));
    assign push         = i_valid && o_ready;
    assign head_pair    = head;
    assign o_busy       = (state_q != ST_IDLE) || (count != '0);
    assign o_fifo_count = count;
    assign o_CS_n       = stb_n_q;
    assign o_WR_n       = stb_n_q;
    assign o_A0         = a0_q;
    assign o_D          = bus_q;

    // A new pair starts from IDLE, or straight out of the last DATA_WAIT cycle
    // so queued writes run back to back with no IDLE gap.
    assign start = !empty && ((state_q == ST_IDLE) ||
                              (state_q == ST_DATA_WAIT && cnt_q == '0));

    opll_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i ({i_addr, i_data}),
        .pop_i   (start),
        .rdata_o (head),
        .count_o (count),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stb_n_q <= 1'b1;
            a0_q    <= 1'b0;
            bus_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stb_n_q <= stb_n_d;
            a0_q    <= a0_d;
            bus_q   <= bus_d;
            data_q  <= data_d;
        end
    end

    // cnt_q holds the remaining cycles of the current phase minus one; a
    // phase ends on the cycle it reads zero, and loads count from N-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
        stb_n_d = stb_n_q;
        a0_d    = a0_q;
        bus_d   = bus_q;
        data_d  = data_q;
        case (state_q)
            ST_ADDR_STB: if (cnt_q == '0) begin
                stb_n_d = 1'b1;
                state_d = ST_ADDR_WAIT;
                cnt_d   = CW'(ADDR_WAIT - 1);
            end
            ST_ADDR_WAIT: if (cnt_q == '0) begin
                stb_n_d = 1'b0;
                a0_d    = 1'b1;
                bus_d   = data_q;
                state_d = ST_DATA_STB;
                cnt_d   = CW'(WR_PULSE - 1);
            end
            ST_DATA_STB: if (cnt_q == '0) begin
                stb_n_d = 1'b1;
                state_d = ST_DATA_WAIT;
                cnt_d   = CW'(DATA_WAIT - 1);
            end
            ST_DATA_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            stb_n_d = 1'b0;
            a0_d    = 1'b0;
            bus_d   = head_pair.addr;
            data_d  = head_pair.data;
            state_d = ST_ADDR_STB;
            cnt_d   = CW'(WR_PULSE - 1);
        end
    end

endmodule

// File: tb/tb_opll_write_sequencer.sv
// tb_opll_write_sequencer: scoreboard bench for the default-timing sequencer
// (instance a) and a 1/1/1-timing instance (instance b).
module tb_opll_write_sequencer;

    localparam int PER_A = 104, DOFF_A = 16, PUL_A = 4;
    localparam int PER_B = 4, DOFF_B = 2, PUL_B = 1;

    typedef struct {
        logic       a0;
        logic [7:0] d;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [7:0] a_addr = '0, a_data = '0, b_addr = '0, b_data = '0;
    logic       a_ready, a_busy, a_cs, a_wr, a_a0;
    logic       b_ready, b_busy, b_cs, b_wr, b_a0;
    logic [2:0] a_cnt, b_cnt;
    logic [7:0] a_d, b_d;

    int   cyc = 0, checks = 0, failures = 0;
    int   last_a = -1000, last_b = -1000;
    int   falls_a = 0, fall_at_a = 0, fall_at_b = 0;
    logic prev_a = 1'b1, prev_b = 1'b1;
    ev_t  qa[$], qb[$];
    ev_t  ea, eb;

    opll_write_sequencer dut_a (
        .clk(clk), .reset(reset), .i_valid(a_valid), .i_addr(a_addr), .i_data(a_data),
        .o_ready(a_ready), .o_busy(a_busy), .o_fifo_count(a_cnt),
        .o_CS_n(a_cs), .o_WR_n(a_wr), .o_A0(a_a0), .o_D(a_d)
    );

    opll_write_sequencer #(.WR_PULSE(1), .ADDR_WAIT(1), .DATA_WAIT(1)) dut_b (
        .clk(clk), .reset(reset), .i_valid(b_valid), .i_addr(b_addr), .i_data(b_data),
        .o_ready(b_ready), .o_busy(b_busy), .o_fifo_count(b_cnt),
        .o_CS_n(b_cs), .o_WR_n(b_wr), .o_A0(b_a0), .o_D(b_d)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Each strobe is expected to fall at the later of one edge after
    // acceptance and one full period after the previous pair started.
    task automatic expect_pair(input bit sel, input logic [7:0] ad, input logic [7:0] dt, input int e);
        int s;
        if (sel) begin
            s = (e + 1 > last_b + PER_B) ? e + 1 : last_b + PER_B;
            last_b = s;
            qb.push_back('{1'b0, ad, s});
            qb.push_back('{1'b1, dt, s + DOFF_B});
        end else begin
            s = (e + 1 > last_a + PER_A) ? e + 1 : last_a + PER_A;
            last_a = s;
            qa.push_back('{1'b0, ad, s});
            qa.push_back('{1'b1, dt, s + DOFF_A});
        end
    endtask

    task automatic push(input bit sel, input logic [7:0] ad, input logic [7:0] dt, output int e);
        logic rdy;
        e = -1;
        if (sel) begin b_valid = 1'b1; b_addr = ad; b_data = dt; end
        else begin a_valid = 1'b1; a_addr = ad; a_data = dt; end
        for (int i = 0; i < 400 && e < 0; i++) begin
            rdy = sel ? b_ready : a_ready;
            if (rdy) e = cyc + 1;
            @(negedge clk);
        end
        if (sel) b_valid = 1'b0; else a_valid = 1'b0;
        if (e < 0) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: got no accept expected accept within 400 cycles (cycle %0d)", cyc);
        end else expect_pair(sel, ad, dt, e);
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        while ((sel ? b_busy : a_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(sel ? "b_idle_timeout" : "a_idle_timeout", sel ? b_busy : a_busy, 0);
    endtask

    always @(negedge clk) begin
        if (prev_a && !a_wr) begin
            falls_a++;
            fall_at_a = cyc;
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_strobe: got strobe A0=%0d D=%0h expected none (cycle %0d)", a_a0, a_d, cyc);
            end else begin
                ea = qa.pop_front();
                check("a_A0", a_a0, ea.a0);
                check("a_D", a_d, ea.d);
                check("a_fall_cycle", cyc, ea.cyc);
            end
        end
        if (!prev_a && a_wr) check("a_pulse_width", cyc - fall_at_a, PUL_A);
        if (a_cs !== a_wr) check("a_cs_eq_wr", a_cs, a_wr);
        prev_a = a_wr;
    end

    always @(negedge clk) begin
        if (prev_b && !b_wr) begin
            fall_at_b = cyc;
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_strobe: got strobe A0=%0d D=%0h expected none (cycle %0d)", b_a0, b_d, cyc);
            end else begin
                eb = qb.pop_front();
                check("b_A0", b_a0, eb.a0);
                check("b_D", b_d, eb.d);
                check("b_fall_cycle", cyc, eb.cyc);
            end
        end
        if (!prev_b && b_wr) check("b_pulse_width", cyc - fall_at_b, PUL_B);
        if (b_cs !== b_wr) check("b_cs_eq_wr", b_cs, b_wr);
        prev_b = b_wr;
    end

    initial begin
        int e0, e, p, f;
        repeat (3) @(negedge clk);
        check("rst_CS_n", a_cs, 1);
        check("rst_WR_n", a_wr, 1);
        check("rst_A0", a_a0, 0);
        check("rst_D", a_d, 0);
        check("rst_ready", a_ready, 0);
        check("rst_busy", a_busy, 0);
        check("rst_count", a_cnt, 0);
        check("rst_b_WR_n", b_wr, 1);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", a_ready, 1);

        // Single write: pin timing relative to the accept edge.
        push(0, 8'h10, 8'h61, e0);
        check("busy_after_push", a_busy, 1);
        repeat (3) @(negedge clk);
        check("single_addr_WR_n", a_wr, 0);
        check("single_addr_A0", a_a0, 0);
        check("single_addr_D", a_d, 8'h10);
        repeat (13) @(negedge clk);
        check("single_wait_WR_n", a_wr, 1);
        check("single_wait_D_hold", a_d, 8'h10);
        @(negedge clk);
        check("single_data_WR_n", a_wr, 0);
        check("single_data_A0", a_a0, 1);
        check("single_data_D", a_d, 8'h61);
        repeat (87) @(negedge clk);
        check("single_busy_c104", a_busy, 1);
        @(negedge clk);
        check("single_busy_c105", a_busy, 0);

        // Three consecutive pushes: back-to-back pairs 104 clocks apart.
        push(0, 8'h30, 8'h31, e);
        push(0, 8'h40, 8'h41, e);
        push(0, 8'h50, 8'h51, e);
        wait_idle(0);
        check("three_all_seen", qa.size(), 0);

        // Burst into a depth-4 FIFO: fills to 4, next push stalls, and a
        // push coinciding with a pop on a full FIFO is refused.
        push(0, 8'h20, 8'hA0, e0);
        for (int i = 1; i < 5; i++) push(0, 8'h20 + 8'(i), 8'hA0 + 8'(i), e);
        check("burst_count_full", a_cnt, 4);
        check("burst_ready_low", a_ready, 0);
        p = e0 + 1 + PER_A;
        a_valid = 1'b1; a_addr = 8'h25; a_data = 8'hA5;
        while (cyc < p - 1) @(negedge clk);
        check("full_ready_before_pop", a_ready, 0);
        check("full_count_before_pop", a_cnt, 4);
        @(negedge clk);
        check("full_pop_refused_count", a_cnt, 3);
        check("full_ready_after_pop", a_ready, 1);
        push(0, 8'h25, 8'hA5, e);
        check("stalled_accept_edge", e, p + 1);
        wait_idle(0);
        check("burst_all_seen", qa.size(), 0);

        // Reset during DATA_WAIT with two pairs still queued.
        push(0, 8'h60, 8'h61, e0);
        push(0, 8'h70, 8'h71, e);
        push(0, 8'h80, 8'h81, e);
        while (cyc < e0 + 50) @(negedge clk);
        check("pre_reset_WR_n", a_wr, 1);
        check("pre_reset_count", a_cnt, 2);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_CS_n", a_cs, 1);
        check("midrst_WR_n", a_wr, 1);
        check("midrst_A0", a_a0, 0);
        check("midrst_D", a_d, 0);
        check("midrst_count", a_cnt, 0);
        qa.delete();
        last_a = -1000;
        reset = 1'b0;
        f = falls_a;
        repeat (300) @(negedge clk);
        check("post_reset_no_strobes", falls_a, f);
        check("post_reset_busy", a_busy, 0);

        // Minimum timing: single-cycle strobes and a 4-clock period.
        push(1, 8'h01, 8'hAA, e);
        push(1, 8'h02, 8'hBB, e);
        push(1, 8'h03, 8'hCC, e);
        wait_idle(1);
        check("min_all_seen", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
